// File: rtl/tick_pkg.sv
// Shared definitions for the programmable tick generator: mode encodings,
// reset divisor default and channel-index width helper.
package tick_pkg;

  typedef enum logic [1:0] {
    MODE_PERIODIC = 2'b00,
    MODE_ONESHOT  = 2'b01
  } mode_t;

  localparam logic [23:0] DIV_RESET_DEF = 24'h4FFFFF;

  // Index width for a channel count; a single channel still gets one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: programmable divider with periodic / one-shot modes,
// registered tick strobe, divided square wave and one-shot busy flag.
module tick_channel
  import tick_pkg::*;
#(
  parameter int               WIDTH     = 24,
  parameter logic [WIDTH-1:0] DIV_RESET = WIDTH'(DIV_RESET_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [1:0]       cfg_mode,
  input  logic             enable,
  input  logic             start,
  output logic             tick,
  output logic             sq,
  output logic             busy
);

  logic [WIDTH-1:0] div;
  logic [WIDTH-1:0] cnt;
  logic [1:0]       mode;
  logic             oneshot;
  logic             active;

  // Reserved encodings fall through to periodic behaviour.
  assign oneshot = (mode == MODE_ONESHOT);
  assign active  = enable && (!oneshot || busy);

  always_ff @(posedge clk) begin
    if (reset) begin
      div  <= DIV_RESET;
      mode <= MODE_PERIODIC;
      cnt  <= '0;
      tick <= 1'b0;
      sq   <= 1'b0;
      busy <= 1'b0;
    end else if (cfg_load) begin
      // A start in the same cycle arms the timer with the new settings.
      div  <= cfg_div;
      mode <= cfg_mode;
      cnt  <= '0;
      tick <= 1'b0;
      sq   <= 1'b0;
      busy <= start && (cfg_mode == MODE_ONESHOT);
    end else if (start) begin
      cnt  <= '0;
      tick <= 1'b0;
      if (oneshot) busy <= 1'b1;
    end else if (active) begin
      if (cnt == div) begin
        cnt  <= '0;
        tick <= 1'b1;
        sq   <= ~sq;
        if (oneshot) busy <= 1'b0;
      end else begin
        cnt  <= cnt + WIDTH'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/tick_gen.sv
// Multi-channel programmable tick generator: decodes the shared cfg bus into
// per-channel loads and replicates tick_channel CHANNELS times.
module tick_gen
  import tick_pkg::*;
#(
  parameter int               CHANNELS  = 4,
  parameter int               WIDTH     = 24,
  parameter logic [WIDTH-1:0] DIV_RESET = WIDTH'(DIV_RESET_DEF)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_we,
  input  logic [ch_w(CHANNELS)-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]            cfg_div,
  input  logic [1:0]                  cfg_mode,
  input  logic [CHANNELS-1:0]         enable,
  input  logic [CHANNELS-1:0]         start,
  output logic [CHANNELS-1:0]         tick,
  output logic [CHANNELS-1:0]         sq,
  output logic [CHANNELS-1:0]         busy
);

  localparam int CW = ch_w(CHANNELS);

  logic [CHANNELS-1:0] cfg_load;

  // Out-of-range indices match no channel and are dropped.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign cfg_load[g] = cfg_we && (cfg_ch == CW'(g));

    tick_channel #(
      .WIDTH     (WIDTH),
      .DIV_RESET (DIV_RESET)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .cfg_load (cfg_load[g]),
      .cfg_div  (cfg_div),
      .cfg_mode (cfg_mode),
      .enable   (enable[g]),
      .start    (start[g]),
      .tick     (tick[g]),
      .sq       (sq[g]),
      .busy     (busy[g])
    );
  end

endmodule
